// File: rtl/sensor_gate_sched_pkg.sv
// Shared types and defaults for the sensor-gate scheduler family.
package sensor_sched_pkg;

    localparam int N_DEF        = 10;
    localparam int DWELL_W_DEF  = 8;
    localparam int GAP_DEF      = 2;
    localparam int COINC_TH_DEF = 3;

    // Scheduler FSM states, also exported on the debug port.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARB   = 2'd1,
        ST_DWELL = 2'd2,
        ST_GAP   = 2'd3
    } sched_state_t;

    // Lane index for the default lane count.
    typedef logic [$clog2(N_DEF)-1:0] lane_idx_t;

endpackage

// File: rtl/sensor_gate_sched_rr_pick.sv
// Combinational round-robin picker: first set request at index >= ptr,
// wrapping from N-1 back to 0.
module rr_pick_n #(
    parameter int N     = 10,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             found_o
);

    int w_lane;

    // Walk offsets from the farthest to the nearest so the nearest hit wins.
    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        w_lane  = 0;
        for (int k = N - 1; k >= 0; k--) begin
            w_lane = int'(ptr_i) + k;
            if (w_lane >= N) begin
                w_lane = w_lane - N;
            end
            if (w_lane < N && req_i[w_lane]) begin
                idx_o   = IDX_W'(w_lane);
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sensor_gate_sched.sv
// Round-robin sensor-gate scheduler: one gate at a time, held for a
// programmable dwell, followed by a fixed guard gap. Also flags when
// enough masked sensors are active at once.
module sensor_gate_sched
    import sensor_sched_pkg::*;
#(
    parameter int N        = N_DEF,
    parameter int DWELL_W  = DWELL_W_DEF,
    parameter int GAP      = GAP_DEF,
    parameter int COINC_TH = COINC_TH_DEF
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic [N-1:0]         sensor_i,
    input  logic [N-1:0]         mask_i,
    input  logic [DWELL_W-1:0]   dwell_i,
    input  logic                 done_i,
    output logic [N-1:0]         gate_o,
    output logic                 grant_valid_o,
    output logic [$clog2(N)-1:0] grant_idx_o,
    output logic                 busy_o,
    output logic                 coinc_o,
    output logic [15:0]          grant_cnt_o,
    output sched_state_t         dbg_state_o
);

    localparam int IDX_W = $clog2(N);
    localparam int CNT_W = $clog2(N + 1);
    localparam int GAP_W = (GAP > 0) ? $clog2(GAP + 1) : 1;

    sched_state_t       r_state;
    sched_state_t       w_next;
    logic [N-1:0]       r_gate;
    logic               r_valid;
    logic [IDX_W-1:0]   r_idx;
    logic               r_busy;
    logic               r_coinc;
    logic [15:0]        r_grant_cnt;
    logic [IDX_W-1:0]   r_ptr;
    logic [DWELL_W-1:0] r_cnt;
    logic [GAP_W-1:0]   r_gap;

    logic [N-1:0]       w_req;
    logic [IDX_W-1:0]   w_pick_idx;
    logic               w_found;
    logic               w_release;
    logic [DWELL_W-1:0] w_dwell_eff;
    logic [CNT_W-1:0]   w_active;

    assign w_req       = sensor_i & mask_i;
    assign w_release   = (r_cnt == DWELL_W'(1)) || done_i;
    assign w_dwell_eff = (dwell_i == '0) ? DWELL_W'(1) : dwell_i;

    rr_pick_n #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_pick (
        .req_i   (w_req),
        .ptr_i   (r_ptr),
        .idx_o   (w_pick_idx),
        .found_o (w_found)
    );

    // Count active masked sensors for the coincidence flag.
    always_comb begin
        w_active = '0;
        for (int i = 0; i < N; i++) begin
            w_active = w_active + CNT_W'(w_req[i]);
        end
    end

    // Next-state logic; dropping enable returns to IDLE from any state.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (en_i) w_next = ST_ARB;
            end
            ST_ARB: begin
                if (!en_i)        w_next = ST_IDLE;
                else if (w_found) w_next = ST_DWELL;
            end
            ST_DWELL: begin
                if (!en_i)          w_next = ST_IDLE;
                else if (w_release) w_next = (GAP > 0) ? ST_GAP : ST_ARB;
            end
            ST_GAP: begin
                if (!en_i)                     w_next = ST_IDLE;
                else if (r_gap <= GAP_W'(1))   w_next = ST_ARB;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // State register plus grant, pointer, counters and registered outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= ST_IDLE;
            r_gate      <= '0;
            r_valid     <= 1'b0;
            r_idx       <= '0;
            r_busy      <= 1'b0;
            r_coinc     <= 1'b0;
            r_grant_cnt <= '0;
            r_ptr       <= '0;
            r_cnt       <= '0;
            r_gap       <= '0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next != ST_IDLE);
            r_coinc <= (int'(w_active) >= COINC_TH);
            if (!en_i) begin
                // Pointer and grant count survive a disable.
                r_gate  <= '0;
                r_valid <= 1'b0;
            end else begin
                case (r_state)
                    ST_ARB: begin
                        if (w_found) begin
                            r_gate  <= N'(1) << w_pick_idx;
                            r_valid <= 1'b1;
                            r_idx   <= w_pick_idx;
                            r_cnt   <= w_dwell_eff;
                            if (r_grant_cnt != 16'hFFFF) begin
                                r_grant_cnt <= r_grant_cnt + 16'd1;
                            end
                        end
                    end
                    ST_DWELL: begin
                        if (w_release) begin
                            r_gate  <= '0;
                            r_valid <= 1'b0;
                            r_ptr   <= (r_idx == IDX_W'(N - 1)) ? '0 : r_idx + IDX_W'(1);
                            r_gap   <= GAP_W'(GAP);
                        end else begin
                            r_cnt <= r_cnt - DWELL_W'(1);
                        end
                    end
                    ST_GAP: begin
                        if (r_gap > GAP_W'(1)) begin
                            r_gap <= r_gap - GAP_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign gate_o        = r_gate;
    assign grant_valid_o = r_valid;
    assign grant_idx_o   = r_idx;
    assign busy_o        = r_busy;
    assign coinc_o       = r_coinc;
    assign grant_cnt_o   = r_grant_cnt;
    assign dbg_state_o   = r_state;

endmodule

// File: doc/sensor_gate_sched.md
Name: sensor_gate_sched

Overview:
Sequential scheduler for the sensor-gate array in the vga_lcd control path. It arbitrates among up to N sensor requests and grants one gate at a time, round-robin. Each grant is held for a programmable dwell time, followed by a fixed guard gap. It also flags multi-sensor coincidence for the downstream product-term gating logic.

Parameters:
N, 10, number of sensor/gate lanes
DWELL_W, 8, width of dwell counter and dwell_i
GAP, 2, guard cycles between a release and the next arbitration (0 allowed)
COINC_TH, 3, active masked-sensor count at or above which coinc_o asserts

Ports:
clk_i  in  1  system clock
rst_i  in  1  reset, asynchronous, active-high
en_i  in  1  scheduler enable
sensor_i  in  N  raw sensor request levels
mask_i  in  N  per-lane enable (1 = lane may be granted)
dwell_i  in  DWELL_W  grant hold length in cycles; 0 treated as 1
done_i  in  1  early-release handshake from the gated consumer
gate_o  out  N  one-hot gate enable (isg lanes), all-zero when no grant
grant_valid_o  out  1  a grant is active
grant_idx_o  out  $clog2(N)  index of current or last grant
busy_o  out  1  FSM not in IDLE
coinc_o  out  1  registered coincidence flag
grant_cnt_o  out  16  saturating count of grants issued

Behaviour:
- Clock and reset: single clock clk_i; rst_i is asynchronous and active-high. Reset values: state IDLE, gate_o 0, grant_valid_o 0, grant_idx_o 0, busy_o 0, coinc_o 0, grant_cnt_o 0, rr pointer 0, dwell and gap counters 0.
- All outputs are registered.
- FSM states: IDLE, ARB, DWELL, GAP.
- IDLE: if en_i = 1, go to ARB next cycle.
- ARB:
  - req = sensor_i & mask_i.
  - If req = 0, stay in ARB.
  - Otherwise, pick the first set bit at index >= ptr, wrapping from N-1 to 0.
  - On the next edge: gate_o = one-hot(idx), grant_valid_o = 1, grant_idx_o = idx, cnt = max(dwell_i, 1), grant_cnt_o += 1 (saturating at 0xFFFF), go to DWELL.
  - Latency: a request visible in ARB produces gate_o one cycle later.
- DWELL:
  - cnt decrements every cycle. Gate stays high for exactly max(dwell_i, 1) cycles.
  - Release happens when cnt = 1 or done_i = 1, whichever comes first. done_i on the first DWELL cycle gives a 1-cycle grant.
  - On release edge: gate_o = 0, grant_valid_o = 0, grant_idx_o holds its value, ptr = idx+1 (wraps N-1 to 0).
  - After release, go to GAP if GAP > 0, else to ARB.
  - The requester dropping sensor_i during DWELL does not shorten the grant.
  - dwell_i is sampled only at grant time; later changes do not affect the active grant.
- GAP: hold for GAP cycles with gate_o = 0, then go to ARB.
- en_i = 0 in any non-IDLE state: on the next edge gate_o = 0, grant_valid_o = 0, state IDLE. ptr and grant_cnt_o are preserved.
- busy_o = (state != IDLE).
- Coincidence: every cycle, coinc_o <= (popcount(sensor_i & mask_i) >= COINC_TH). It runs independently of the FSM and of en_i.
- Invariants: gate_o is never more than one-hot. gate_o != 0 if and only if grant_valid_o = 1.
- Reset asserted mid-DWELL clears gate_o immediately (asynchronous).

Decomposition:
- Shared package sensor_sched_pkg: FSM state enum, lane-index typedef sized from N, and GAP/COINC_TH defaults.
- One sub-module, rr_pick_n: combinational round-robin first-set-from-pointer picker (inputs req and ptr; outputs idx and found). It is reused by later multi-gate variants.

Test Plan:
- Reset then en_i=1, mask_i=all ones, sensor_i=0b0000100000 (lane 5), dwell_i=4, GAP=2 -> gate_o=0b0000100000 for exactly 4 cycles starting 1 cycle after ARB; grant_cnt_o=1; next grant no earlier than 2 gap cycles later.
- Lanes 2, 7, 9 held asserted continuously, dwell_i=1 -> grants in order 2, 7, 9, 2, ... (round-robin wrap); ptr=0 after granting 9.
- dwell_i=10, done_i pulsed on the 3rd DWELL cycle -> gate_o low after 3 cycles; FSM enters GAP.
- dwell_i=0 -> 1-cycle grant. mask_i bit 5 = 0 with sensor 5 high -> lane 5 is never granted.
- en_i dropped mid-DWELL -> gate_o=0 next cycle, busy_o=0. Re-enable -> arbitration resumes from the preserved ptr.
- Sensors 0, 3, 6 active with COINC_TH=3 -> coinc_o=1 one cycle later. Masking lane 3 -> coinc_o=0 the next cycle. Async rst_i mid-grant -> all outputs 0 without waiting for a clock edge.
